complex_div_fx: RTL and testbench
=================================

// Module: complex_div_fx
// PURPOSE
//  Sequential fixed-point complex divider: q = a / b = a*conj(b) / |b|^2, Q5.11 in/out.
//  Inverse companion of the complex multiplier; used for channel equalisation and normalisation.
//  Radix-2 restoring division, one quotient bit per cycle. Valid/ready on both sides.
// PARAMETERS
//  WIDTH  16  operand/result width (signed, two's complement)
//  FRAC   11  fractional bits of a, b and q
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block idle, can accept
//  a_re,a_im  in   WIDTH  dividend (signed Q5.11)
//  b_re,b_im  in   WIDTH  divisor (signed Q5.11)
//  out_valid  out  1      result valid, held until out_ready
//  out_ready  in   1      downstream accepts result
//  q_re,q_im  out  WIDTH  quotient (signed Q5.11, saturated)
//  ovf        out  1      either component saturated (valid with out_valid)
//  dz         out  1      divisor was 0+0j (valid with out_valid)
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; q_re=q_im=0; ovf=dz=0. Reset at any point aborts the op.
//  FSM: IDLE -> PREP -> DIV -> FIX -> HOLD -> IDLE.
//   IDLE: in_ready=1; in_valid&in_ready at edge = cycle 0: register a, b; go PREP.
//   PREP (cycle 1): nr = ac+bd, ni = bc-ad (2*WIDTH+1 signed); den = c^2+d^2 (2*WIDTH unsigned);
//     store signs, magnitudes |nr|,|ni|. den==0 -> dz=1, skip to FIX; else DIV.
//   DIV (cycles 2..ITER+1): two restoring dividers in lockstep, shared den;
//     dividend = |n| << FRAC, ITER = 2*WIDTH+1+FRAC (=44 default) cycles, MSB first.
//   FIX (cycle ITER+2): apply sign; magnitude truncated toward zero.
//     Clamp positive > 2^(WIDTH-1)-1 to MAX, negative magnitude > 2^(WIDTH-1) to MIN; ovf=1 if any clamp.
//     dz path: each component = MAX if numerator>0, MIN if <0, 0 if ==0; ovf=0.
//   HOLD: out_valid=1 from cycle ITER+3 (47 default; dz path: cycle 3). q/ovf/dz stable while out_valid&!out_ready.
//     out_valid&out_ready -> out_valid=0, IDLE; in_ready rises the following cycle (no same-cycle accept).
//  in_ready=0 in all states but IDLE; in_valid ignored there. Operand inputs need only be stable at the accept edge.
//  Latency fixed, data-independent (except dz). Throughput 1 op per ITER+4 cycles min.
//  No internal overflow: products 2*WIDTH bits, sums 2*WIDTH+1, remainder 2*WIDTH+1 bits.
// CONFIGURATION
//  CDIV_ROUND_EN defined: one extra quotient bit computed (ITER+1 cycles); magnitude rounded
//    half away from zero before sign/saturation; all latencies +1 (out_valid at cycle 48).
//  Undefined: truncation toward zero, timings as above.
// STRUCTURE
//  fx_pkg.vh: WIDTH/FRAC defaults, MAX_VAL/MIN_VAL, FSM state encodings, ITER formula.
//  Sub-module udiv_restoring (unsigned; start, step per cycle, quotient/remainder out),
//    instantiated twice (re, im). FSM, PREP multiplies, sign/saturation stay in complex_div_fx.
// TESTING
//  a=(2048,0) b=(2048,0) -> q=(2048,0), ovf=0, dz=0, out_valid exactly at cycle 47.
//  a=(2048,2048) b=(2048,-2048) [(1+j)/(1-j)] -> q=(0,2048).
//  a=(2048,0) b=(6144,0) -> q=(682,0); with CDIV_ROUND_EN q=(683,0), out_valid at cycle 48.
//  a=(32767,-32768) b=(1,0) -> q=(32767,-32768), ovf=1.
//  b=(0,0), a=(-100,0) -> q=(-32768,0), dz=1, ovf=0, out_valid at cycle 3.
//  out_ready=0 for 5 cycles -> q stable, in_ready=0; assert rst in DIV -> outputs 0, in_ready=1, next op correct.

Source files
------------

// File: rtl/complex_div_fx_pkg.sv
// complex_div_fx_pkg
//   Shared constants and helpers for the complex_div_fx block: operand widths,
//   Q-format, divider iteration count, saturation limits and FSM encodings.
//   Configuration macro: CDIV_ROUND_EN. When it is defined the divider makes one
//   extra quotient bit so that the result can be rounded half away from zero.
package complex_div_fx_pkg;

   localparam int WIDTH = 16;            // operand/result width (signed)
   localparam int FRAC  = 11;            // fractional bits (Q5.11)
   localparam int NW    = 2*WIDTH + 1;   // signed numerator width (sum of two products)
   localparam int DW    = 2*WIDTH;       // unsigned denominator width
   localparam int ITER  = NW + FRAC;     // quotient bits for truncation

`ifdef CDIV_ROUND_EN
   localparam int RND = 1;
`else
   localparam int RND = 0;
`endif

   localparam int QBITS = ITER + RND;    // quotient bits actually produced
   localparam int MAGW  = ITER + 1;      // rounded magnitude may carry one bit past ITER
   localparam int CNTW  = $clog2(QBITS);

   localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_PREP = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_HOLD = 3'd4;

   // Apply sign to an unsigned magnitude and clamp; returns {ovf, value}.
   // A negative magnitude of exactly 2^(WIDTH-1) is representable as MIN_VAL.
   function automatic logic [WIDTH:0] sat_fx(input logic neg, input logic [MAGW-1:0] mag);
      logic [WIDTH-1:0] lo;
      lo = mag[WIDTH-1:0];
      if (!neg) begin
         if (mag > MAGW'(2**(WIDTH-1) - 1)) return {1'b1, MAX_VAL};
         return {1'b0, lo};
      end
      if (mag > MAGW'(2**(WIDTH-1))) return {1'b1, MIN_VAL};
      return {1'b0, -lo};
   endfunction

   // Division by zero: full-scale in the direction of the dividend component.
   function automatic logic [WIDTH-1:0] dz_fx(input logic signed [WIDTH-1:0] a);
      if (a > 0) return MAX_VAL;
      if (a < 0) return MIN_VAL;
      return '0;
   endfunction

endpackage

// File: rtl/complex_div_fx_if.sv
// complex_div_fx_if
//   Operand / result handshake bundle for complex_div_fx.
//   Input side : in_valid, in_ready, a_re, a_im, b_re, b_im (signed Q5.11)
//   Output side: out_valid, out_ready, q_re, q_im (signed Q5.11), ovf, dz
//   Modports: slave (the divider), master (the producer/consumer driving it).
interface complex_div_fx_if;
   import complex_div_fx_pkg::*;

   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] a_re;
   logic signed [WIDTH-1:0] a_im;
   logic signed [WIDTH-1:0] b_re;
   logic signed [WIDTH-1:0] b_im;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] q_re;
   logic signed [WIDTH-1:0] q_im;
   logic                    ovf;
   logic                    dz;

   modport slave (
      input  in_valid, a_re, a_im, b_re, b_im, out_ready,
      output in_ready, out_valid, q_re, q_im, ovf, dz
   );

   modport master (
      output in_valid, a_re, a_im, b_re, b_im, out_ready,
      input  in_ready, out_valid, q_re, q_im, ovf, dz
   );

endinterface

// File: rtl/complex_div_fx_udiv_restoring.sv
// complex_div_fx_udiv_restoring
//   Unsigned radix-2 restoring divider, one quotient bit per i_step, MSB first.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_start        : load i_dividend, clear the partial remainder
//   i_step         : perform one shift/subtract iteration
//   i_dividend     : NBITS-bit dividend
//   i_divisor      : DBITS-bit divisor, held stable while stepping
//   o_quot         : quotient, complete after NBITS steps
module complex_div_fx_udiv_restoring
   import complex_div_fx_pkg::*;
#(
   parameter int NBITS = QBITS,
   parameter int DBITS = DW
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_step,
   input  logic [NBITS-1:0] i_dividend,
   input  logic [DBITS-1:0] i_divisor,
   output logic [NBITS-1:0] o_quot
);

   // r_q shifts the dividend out at the top while quotient bits enter at the bottom.
   logic [NBITS-1:0] r_q;
   logic [DBITS-1:0] r_rem;
   logic [DBITS:0]   w_sh;
   logic             w_ge;
   logic [DBITS-1:0] w_diff;

   always_comb begin
      w_sh   = {r_rem, r_q[NBITS-1]};
      w_ge   = (w_sh >= {1'b0, i_divisor});
      // Only used when w_ge, where the true difference is below the divisor.
      w_diff = w_sh[DBITS-1:0] - i_divisor;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_q   <= '0;
         r_rem <= '0;
      end else if (i_start) begin
         r_q   <= i_dividend;
         r_rem <= '0;
      end else if (i_step) begin
         r_q   <= {r_q[NBITS-2:0], w_ge};
         r_rem <= w_ge ? w_diff : w_sh[DBITS-1:0];
      end
   end

   assign o_quot = r_q;

endmodule

// File: rtl/complex_div_fx.sv
// complex_div_fx
//   Sequential fixed-point complex divider q = a / b = a*conj(b) / |b|^2, Q5.11.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset, aborts any operation
//   bus      : complex_div_fx_if.slave (valid/ready operands in, valid/ready result out,
//              q_re/q_im saturated quotient, ovf = a component clamped, dz = divisor 0+0j)
//   Configuration macro: CDIV_ROUND_EN (round half away from zero, one extra cycle);
//   default is truncation toward zero.
module complex_div_fx (
   input logic               clk,
   input logic               rst,
   complex_div_fx_if.slave   bus
);
   import complex_div_fx_pkg::*;

   logic [2:0]              r_state;
   logic signed [WIDTH-1:0] r_a_re, r_a_im, r_b_re, r_b_im;
   logic signed [WIDTH-1:0] r_q_re, r_q_im;
   logic [DW-1:0]           r_den;
   logic                    r_neg_re, r_neg_im;
   logic                    r_ovf, r_dz;
   logic [CNTW-1:0]         r_cnt;

   logic signed [DW-1:0]    w_ac, w_bd, w_bc, w_ad, w_cc, w_dd;
   logic signed [NW-1:0]    w_nr, w_ni;
   logic [NW-1:0]           w_mag_nr, w_mag_ni;
   logic [DW-1:0]           w_den;
   logic                    w_start, w_step;
   logic [QBITS-1:0]        w_quot_re, w_quot_im;
   logic [MAGW-1:0]         w_mag_q_re, w_mag_q_im;
   logic [WIDTH:0]          w_sat_re, w_sat_im;

   always_comb begin
      w_ac     = r_a_re * r_b_re;
      w_bd     = r_a_im * r_b_im;
      w_bc     = r_a_im * r_b_re;
      w_ad     = r_a_re * r_b_im;
      w_cc     = r_b_re * r_b_re;
      w_dd     = r_b_im * r_b_im;
      w_nr     = NW'(w_ac) + NW'(w_bd);
      w_ni     = NW'(w_bc) - NW'(w_ad);
      w_den    = w_cc + w_dd;
      w_mag_nr = w_nr[NW-1] ? -w_nr : w_nr;
      w_mag_ni = w_ni[NW-1] ? -w_ni : w_ni;
      w_start  = (r_state == ST_PREP);
      w_step   = (r_state == ST_DIV);
`ifdef CDIV_ROUND_EN
      // Extra LSB is the half bit: floor(2x)/2 + half-bit == floor(x + 1/2).
      w_mag_q_re = {1'b0, w_quot_re[QBITS-1:1]} + {{(MAGW-1){1'b0}}, w_quot_re[0]};
      w_mag_q_im = {1'b0, w_quot_im[QBITS-1:1]} + {{(MAGW-1){1'b0}}, w_quot_im[0]};
`else
      w_mag_q_re = {1'b0, w_quot_re};
      w_mag_q_im = {1'b0, w_quot_im};
`endif
      w_sat_re = sat_fx(r_neg_re, w_mag_q_re);
      w_sat_im = sat_fx(r_neg_im, w_mag_q_im);
   end

   // Dividers load in PREP straight from the combinational magnitudes.
   complex_div_fx_udiv_restoring #(.NBITS(QBITS), .DBITS(DW)) u_div_re (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (w_start),
      .i_step     (w_step),
      .i_dividend ({w_mag_nr, {(FRAC+RND){1'b0}}}),
      .i_divisor  (r_den),
      .o_quot     (w_quot_re)
   );

   complex_div_fx_udiv_restoring #(.NBITS(QBITS), .DBITS(DW)) u_div_im (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (w_start),
      .i_step     (w_step),
      .i_dividend ({w_mag_ni, {(FRAC+RND){1'b0}}}),
      .i_divisor  (r_den),
      .o_quot     (w_quot_im)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_a_re   <= '0;
         r_a_im   <= '0;
         r_b_re   <= '0;
         r_b_im   <= '0;
         r_q_re   <= '0;
         r_q_im   <= '0;
         r_den    <= '0;
         r_neg_re <= 1'b0;
         r_neg_im <= 1'b0;
         r_ovf    <= 1'b0;
         r_dz     <= 1'b0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_a_re  <= bus.a_re;
                  r_a_im  <= bus.a_im;
                  r_b_re  <= bus.b_re;
                  r_b_im  <= bus.b_im;
                  r_state <= ST_PREP;
               end
            end
            ST_PREP: begin
               r_den    <= w_den;
               r_neg_re <= w_nr[NW-1];
               r_neg_im <= w_ni[NW-1];
               r_dz     <= (w_den == '0);
               r_cnt    <= '0;
               r_state  <= (w_den == '0) ? ST_FIX : ST_DIV;
            end
            ST_DIV: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNTW'(QBITS - 1)) r_state <= ST_FIX;
            end
            ST_FIX: begin
               if (r_dz) begin
                  r_q_re <= dz_fx(r_a_re);
                  r_q_im <= dz_fx(r_a_im);
                  r_ovf  <= 1'b0;
               end else begin
                  r_q_re <= w_sat_re[WIDTH-1:0];
                  r_q_im <= w_sat_im[WIDTH-1:0];
                  r_ovf  <= w_sat_re[WIDTH] | w_sat_im[WIDTH];
               end
               r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (bus.out_ready) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_HOLD);
   assign bus.q_re      = r_q_re;
   assign bus.q_im      = r_q_im;
   assign bus.ovf       = r_ovf;
   assign bus.dz        = r_dz;

endmodule

// File: tb/tb_complex_div_fx.sv
// tb_complex_div_fx
//   Self-checking bench for complex_div_fx: directed vectors, randomized operands
//   against an integer reference model, back-pressure, back-to-back and reset abort.
//   Honours CDIV_ROUND_EN the same way as the design.
module tb_complex_div_fx;
   import complex_div_fx_pkg::*;

`ifdef CDIV_ROUND_EN
   localparam int EXP_LAT = 47;   // edges after accept until out_valid (cycle 48)
   localparam int R3      = 683;
`else
   localparam int EXP_LAT = 46;   // cycle 47
   localparam int R3      = 682;
`endif
   localparam int DZ_LAT = 2;     // cycle 3
   localparam int TMO    = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   complex_div_fx_if bus();

   complex_div_fx u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // {a_re, a_im, b_re, b_im, q_re, q_im, ovf, dz, latency}
   int dir_tab [5][9] = '{
      '{2048,      0, 2048,     0,   2048,      0, 0, 0, EXP_LAT},
      '{2048,   2048, 2048, -2048,      0,   2048, 0, 0, EXP_LAT},
      '{2048,      0, 6144,     0,     R3,      0, 0, 0, EXP_LAT},
      '{32767, -32768,   1,     0,  32767, -32768, 1, 0, EXP_LAT},
      '{-100,      0,    0,     0, -32768,      0, 0, 1, DZ_LAT}
   };

   function automatic int rnd16();
      logic signed [15:0] t;
      t = 16'($urandom);
      return int'(t);
   endfunction

   // |n| * 2^11 / den, truncated or rounded half away from zero, with the sign of n.
   function automatic longint scaled(input longint n, input longint den);
      longint mag, q;
      mag = (n < 0) ? -n : n;
`ifdef CDIV_ROUND_EN
      q = (mag * 4096 + den) / (2 * den);
`else
      q = (mag * 2048) / den;
`endif
      return (n < 0) ? -q : q;
   endfunction

   // Reference: returns {q_re, q_im, ovf, dz}.
   function automatic logic [33:0] model(input int ar, input int ai, input int br, input int bi);
      longint nr, ni, den, qr, qi;
      logic ov;
      nr  = longint'(ar) * br + longint'(ai) * bi;
      ni  = longint'(ai) * br - longint'(ar) * bi;
      den = longint'(br) * br + longint'(bi) * bi;
      if (den == 0) begin
         qr = (ar > 0) ? 32767 : ((ar < 0) ? -32768 : 0);
         qi = (ai > 0) ? 32767 : ((ai < 0) ? -32768 : 0);
         return {16'(qr), 16'(qi), 1'b0, 1'b1};
      end
      qr = scaled(nr, den);
      qi = scaled(ni, den);
      ov = 1'b0;
      if (qr > 32767)  begin qr = 32767;  ov = 1'b1; end
      if (qr < -32768) begin qr = -32768; ov = 1'b1; end
      if (qi > 32767)  begin qi = 32767;  ov = 1'b1; end
      if (qi < -32768) begin qi = -32768; ov = 1'b1; end
      return {16'(qr), 16'(qi), ov, 1'b0};
   endfunction

   // Issue one operation and wait (bounded) for out_valid; the result is not accepted.
   task automatic run_op(input int ar, input int ai, input int br, input int bi,
                         output int lat, output logic [33:0] res);
      @(negedge clk);
      bus.a_re     = 16'(ar);
      bus.a_im     = 16'(ai);
      bus.b_re     = 16'(br);
      bus.b_im     = 16'(bi);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a_re     = 16'($urandom);
      bus.a_im     = 16'($urandom);
      bus.b_re     = 16'($urandom);
      bus.b_im     = 16'($urandom);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < TMO) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = {bus.q_re, bus.q_im, bus.ovf, bus.dz};
   endtask

   task automatic accept();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.q_re, bus.q_im, bus.ovf, bus.dz} !== {1'b1, 1'b0, 34'd0}) begin
         n_err++;
         $display("FAIL reset_state: got rdy=%b vld=%b q=(%0d,%0d) ovf=%b dz=%b, exp rdy=1 vld=0 q=(0,0) ovf=0 dz=0",
                  bus.in_ready, bus.out_valid, bus.q_re, bus.q_im, bus.ovf, bus.dz);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      int lat;
      logic [33:0] res, exp_res;
      for (int i = 0; i < 5; i++) begin
         run_op(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], dir_tab[i][3], lat, res);
         exp_res = {16'(dir_tab[i][4]), 16'(dir_tab[i][5]), 1'(dir_tab[i][6]), 1'(dir_tab[i][7])};
         n_cmp++;
         if (res !== exp_res) begin
            n_err++;
            $display("FAIL directed_%0d_result: got q=(%0d,%0d) ovf=%b dz=%b, exp q=(%0d,%0d) ovf=%0d dz=%0d",
                     i, $signed(res[33:18]), $signed(res[17:2]), res[1], res[0],
                     dir_tab[i][4], dir_tab[i][5], dir_tab[i][6], dir_tab[i][7]);
         end
         n_cmp++;
         if (lat !== dir_tab[i][8]) begin
            n_err++;
            $display("FAIL directed_%0d_latency: got out_valid at cycle %0d, exp cycle %0d",
                     i, lat + 1, dir_tab[i][8] + 1);
         end
         accept();
      end
   endtask

   task automatic test_random();
      int ar, ai, br, bi, lat, exp_lat;
      logic [33:0] res, exp_res;
      for (int i = 0; i < 40; i++) begin
         ar = rnd16();
         ai = rnd16();
         case ($urandom_range(0, 3))
            0: begin br = rnd16(); bi = rnd16(); end
            1: begin br = int'($urandom_range(0, 15)) - 8; bi = int'($urandom_range(0, 15)) - 8; end
            2: begin br = ar + int'($urandom_range(0, 255)) - 128; bi = ai >>> 2; end
            default: begin br = 0; bi = 0; end
         endcase
         if (br > 32767) br = 32767;
         if (br < -32768) br = -32768;
         run_op(ar, ai, br, bi, lat, res);
         exp_res = model(ar, ai, br, bi);
         exp_lat = (br == 0 && bi == 0) ? DZ_LAT : EXP_LAT;
         n_cmp++;
         if (res !== exp_res) begin
            n_err++;
            $display("FAIL random_%0d_result: a=(%0d,%0d) b=(%0d,%0d) got q=(%0d,%0d) ovf=%b dz=%b, exp q=(%0d,%0d) ovf=%b dz=%b",
                     i, ar, ai, br, bi, $signed(res[33:18]), $signed(res[17:2]), res[1], res[0],
                     $signed(exp_res[33:18]), $signed(exp_res[17:2]), exp_res[1], exp_res[0]);
         end
         n_cmp++;
         if (lat !== exp_lat) begin
            n_err++;
            $display("FAIL random_%0d_latency: got cycle %0d, exp cycle %0d", i, lat + 1, exp_lat + 1);
         end
         accept();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [33:0] res, exp_res;
      run_op(-12000, 7000, 3000, -1500, lat, res);
      exp_res = model(-12000, 7000, 3000, -1500);
      n_cmp++;
      if (res !== exp_res) begin
         n_err++;
         $display("FAIL stall_result: got %h, exp %h", res, exp_res);
      end
      // Stall for 5 cycles while offering a new operation that must be ignored.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.a_re     = 16'($urandom);
         bus.b_re     = 16'($urandom);
         @(posedge clk);
         #1;
         n_cmp++;
         if ({bus.out_valid, bus.in_ready, bus.q_re, bus.q_im, bus.ovf, bus.dz} !== {1'b1, 1'b0, exp_res}) begin
            n_err++;
            $display("FAIL stall_hold_%0d: got vld=%b rdy=%b res=%h, exp vld=1 rdy=0 res=%h",
                     i, bus.out_valid, bus.in_ready, {bus.q_re, bus.q_im, bus.ovf, bus.dz}, exp_res);
         end
      end
      // in_valid still high through the handshake edge: must not be taken that cycle.
      accept();
      bus.in_valid = 1'b0;
      n_cmp++;
      if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL release: got vld=%b rdy=%b, exp vld=0 rdy=1", bus.out_valid, bus.in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL no_same_cycle_accept: got rdy=%b, exp rdy=1", bus.in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [33:0] res, exp_res;
      int ops [3][4] = '{'{1000, -2000, 300, 400}, '{-32768, -32768, -32768, 0}, '{5000, 1234, -700, 2500}};
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i][0], ops[i][1], ops[i][2], ops[i][3], lat, res);
         exp_res = model(ops[i][0], ops[i][1], ops[i][2], ops[i][3]);
         n_cmp++;
         if (res !== exp_res || lat !== EXP_LAT) begin
            n_err++;
            $display("FAIL b2b_%0d: got res=%h cycle %0d, exp res=%h cycle %0d",
                     i, res, lat + 1, exp_res, EXP_LAT + 1);
         end
         accept();
      end
   endtask

   task automatic test_reset_mid_div();
      int lat;
      logic [33:0] res;
      // Previous results leave q non-zero; make sure of it before aborting.
      run_op(2048, 2048, 2048, -2048, lat, res);
      accept();
      @(negedge clk);
      bus.a_re = 16'(3000); bus.a_im = 16'(-5000); bus.b_re = 16'(700); bus.b_im = 16'(100);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL busy_in_div: got rdy=%b vld=%b, exp rdy=0 vld=0", bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.q_re, bus.q_im, bus.ovf, bus.dz} !== {1'b1, 1'b0, 34'd0}) begin
         n_err++;
         $display("FAIL reset_abort: got rdy=%b vld=%b q=(%0d,%0d) ovf=%b dz=%b, exp rdy=1 vld=0 q=(0,0) ovf=0 dz=0",
                  bus.in_ready, bus.out_valid, bus.q_re, bus.q_im, bus.ovf, bus.dz);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(2048, 0, 6144, 0, lat, res);
      n_cmp++;
      if (res !== {16'(R3), 16'd0, 1'b0, 1'b0} || lat !== EXP_LAT) begin
         n_err++;
         $display("FAIL after_reset_op: got q=(%0d,%0d) ovf=%b dz=%b cycle %0d, exp q=(%0d,0) ovf=0 dz=0 cycle %0d",
                  $signed(res[33:18]), $signed(res[17:2]), res[1], res[0], lat + 1, R3, EXP_LAT + 1);
      end
      accept();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a_re = '0;
      bus.a_im = '0;
      bus.b_re = '0;
      bus.b_im = '0;
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_div();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_err);
      $fatal(1);
   end

endmodule
